// File: rtl/rnn_pkg.sv
// -----------------------------------------------------------------------------
// rnn_pkg
// Shared constants and types for the RNN input feeder:
//   BYTE_W        - width of one byte lane on the input stream
//   WORD_W        - width of one packed input vector
//   LANES         - byte lanes per input vector
//   ready_state_e - states of the ready/start handshake machine
// -----------------------------------------------------------------------------
package rnn_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = WORD_W / BYTE_W;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } ready_state_e;

endpackage : rnn_pkg

// File: rtl/rnn_fwft_fifo.sv
// -----------------------------------------------------------------------------
// rnn_fwft_fifo
// First-word-fall-through FIFO of WORD_W-bit words. The head word is driven
// combinationally from storage and reads as zero while the FIFO is empty.
// A pop request on an empty FIFO is ignored: no pointer moves, and a push in
// the same cycle still lands and is kept.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset (pointers and count)
//   push_i   in   write data_i at the tail; caller guarantees not full
//   data_i   in   word to push
//   pop_i    in   drop the head word if the FIFO is not empty
//   head_o   out  current head word, zero when empty
//   level_o  out  number of stored words (0..DEPTH)
// -----------------------------------------------------------------------------
module rnn_fwft_fifo
  import rnn_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] head_o,
  output logic [LW-1:0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  logic              empty;
  logic              do_pop;

  assign empty  = (count_q == '0);
  assign do_pop = pop_i && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is deliberately not reset; head_o is masked while empty, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign level_o = count_q;

endmodule : rnn_fwft_fifo

// File: rtl/rnn_input_feeder.sv
// -----------------------------------------------------------------------------
// rnn_input_feeder
// Upstream stage of the RNN core. Packs a byte stream little-endian into
// 32-bit vectors, buffers them in a FWFT FIFO, raises ready to start the core
// once enough words are queued, pops one word per high i_en posedge and keeps
// a sticky underflow flag for requests that find the FIFO empty.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   s_valid    in   byte-stream valid
//   s_data     in   byte-stream data
//   s_ready    out  byte accepted on a posedge with s_valid && s_ready
//   busy       in   core busy flag
//   i_en       in   core word request, one pop per high posedge
//   ready      out  registered start request to the core
//   idata      out  current FIFO head (zero when empty)
//   level      out  words currently buffered
//   underflow  out  sticky: core requested a word from an empty FIFO
// -----------------------------------------------------------------------------
module rnn_input_feeder
  import rnn_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int START_LVL = 2,
  parameter int LW        = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [BYTE_W-1:0] s_data,
  output logic              s_ready,
  input  logic              busy,
  input  logic              i_en,
  output logic              ready,
  output logic [WORD_W-1:0] idata,
  output logic [LW-1:0]     level,
  output logic              underflow
);

  localparam logic [1:0]    LAST_LANE = 2'(LANES - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] ARM_LVL   = LW'(START_LVL);

  // Only lanes 0..2 need holding; lane 3 goes straight from s_data into the FIFO.
  logic [(LANES-1)*BYTE_W-1:0] pack_q, pack_d;
  logic [1:0]                  byte_cnt_q, byte_cnt_d;
  logic                        underflow_q, underflow_d;
  ready_state_e                state_q, state_d;

  logic              accept;
  logic              push;
  logic [WORD_W-1:0] push_word;
  logic [WORD_W-1:0] fifo_head;
  logic [LW-1:0]     fifo_level;
  logic              above_start;

  // Lanes 0..2 are always accepted; only the completing byte waits for space.
  assign s_ready     = (byte_cnt_q != LAST_LANE) || (fifo_level != FULL_LVL);
  assign accept      = s_valid && s_ready;
  assign push        = accept && (byte_cnt_q == LAST_LANE);
  assign push_word   = {s_data, pack_q};
  assign above_start = (fifo_level >= ARM_LVL);

  rnn_fwft_fifo #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (push_word),
    .pop_i   (i_en),
    .head_o  (fifo_head),
    .level_o (fifo_level)
  );

  // Byte packer: lane index equals byte_cnt, wrapping after the last lane.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    pack_d     = pack_q;
    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    pack_d[0*BYTE_W +: BYTE_W] = s_data;
        2'd1:    pack_d[1*BYTE_W +: BYTE_W] = s_data;
        2'd2:    pack_d[2*BYTE_W +: BYTE_W] = s_data;
        default: pack_d = pack_q;
      endcase
    end
  end

  // A request against an empty FIFO latches the error until reset.
  assign underflow_d = underflow_q || (i_en && (fifo_level == '0));

  // Ready handshake: arm only while the core is idle and enough words are
  // queued; leaving ARMED on busy means the core must go idle before re-arming.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!busy && above_start) state_d = ARMED;
      ARMED:   if (busy || !above_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_q  <= '0;
      pack_q      <= '0;
      underflow_q <= 1'b0;
      state_q     <= IDLE;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      pack_q      <= pack_d;
      underflow_q <= underflow_d;
      state_q     <= state_d;
    end
  end

  assign ready     = (state_q == ARMED);
  assign idata     = fifo_head;
  assign level     = fifo_level;
  assign underflow = underflow_q;

endmodule : rnn_input_feeder

// File: tb/tb_rnn_input_feeder.sv
// -----------------------------------------------------------------------------
// tb_rnn_input_feeder
// Scoreboard bench for rnn_input_feeder. The driver completes byte handshakes
// and pushes each assembled word into the expected queue; an independent
// negedge monitor compares the DUT outputs with the reference state and pops
// the queue whenever the core side requests a word.
// -----------------------------------------------------------------------------
module tb_rnn_input_feeder;

  localparam int DEPTH     = 16;
  localparam int START_LVL = 2;
  localparam int LW        = 5;

  logic          clk     = 1'b0;
  logic          reset   = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data  = 8'h00;
  logic          busy    = 1'b0;
  logic          i_en    = 1'b0;
  logic          s_ready;
  logic          ready;
  logic [31:0]   idata;
  logic [LW-1:0] level;
  logic          underflow;

  always #5 clk = ~clk;

  rnn_input_feeder #(
    .DEPTH     (DEPTH),
    .START_LVL (START_LVL),
    .LW        (LW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .busy      (busy),
    .i_en      (i_en),
    .ready     (ready),
    .idata     (idata),
    .level     (level),
    .underflow (underflow)
  );

  // Reference state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];          // words the FIFO must hold, head first
  int          tb_cnt   = 0;      // bytes of the current group accepted so far
  logic [31:0] tb_word  = '0;
  bit          exp_ready = 1'b0;
  bit          exp_uf    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    tb_cnt    = 0;
    tb_word   = '0;
    exp_ready = 1'b0;
    exp_uf    = 1'b0;
  endtask

  // Monitor: compare outputs with the reference, then advance the reference
  // by the inputs that the coming posedge will act on.
  always @(negedge clk) begin
    int          lvl;
    logic [31:0] head;
    lvl  = exp_q.size();
    head = (lvl == 0) ? 32'h0 : exp_q[0];
    check("level",     32'(level),     32'(lvl));
    check("idata",     idata,          head);
    check("s_ready",   32'(s_ready),   32'((tb_cnt != 3) || (lvl != DEPTH)));
    check("ready",     32'(ready),     32'(exp_ready));
    check("underflow", 32'(underflow), 32'(exp_uf));
    if (!reset) begin
      if (!exp_ready) exp_ready = !busy && (lvl >= START_LVL);
      else if (busy || lvl < START_LVL) exp_ready = 1'b0;
      if (i_en) begin
        if (lvl == 0) exp_uf = 1'b1;
        else check("pop_data", idata, exp_q.pop_front());
      end
    end
  end

  // Driver side: a byte handed over on a completed handshake is added to the
  // current group; a finished group becomes an expected FIFO word.
  task automatic take_byte(input logic [7:0] d);
    tb_word[8*tb_cnt +: 8] = d;
    if (tb_cnt == 3) begin
      exp_q.push_back(tb_word);
      tb_cnt = 0;
    end else begin
      tb_cnt++;
    end
  endtask

  // One clock cycle of stimulus; called at posedge+1, returns at posedge+1.
  task automatic cycle(input bit v, input logic [7:0] d, input bit e, output bit acc);
    s_valid = v;
    s_data  = d;
    i_en    = e;
    @(negedge clk);
    acc = v && (s_ready === 1'b1);
    @(posedge clk);
    #1;
    if (acc) take_byte(d);
    s_valid = 1'b0;
    i_en    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      cycle(1'b1, d, 1'b0, acc);
      tries++;
    end
    if (!acc) check("send_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) cycle(1'b0, 8'h00, 1'b0, acc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    logic [7:0]  b3;
    #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_s_ready",   32'(s_ready),   32'd1);
    check("rst_ready",     32'(ready),     32'd0);
    check("rst_idata",     idata,          32'd0);
    check("rst_level",     32'(level),     32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    reset = 1'b0;

    // First word, little-endian packing
    send_word(32'h44332211);
    check("t1_idata", idata,       32'h44332211);
    check("t1_level", 32'(level),  32'd1);
    check("t1_ready", 32'(ready),  32'd0);

    // Second word reaches START_LVL; ready follows one posedge later
    send_word(32'h88776655);
    check("t2_level",       32'(level), 32'd2);
    check("t2_ready_early", 32'(ready), 32'd0);
    idle(1);
    check("t2_ready_up",    32'(ready), 32'd1);
    busy = 1'b1;
    idle(1);
    check("t2_ready_drop",  32'(ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("t2_ready_busy", 32'(ready), 32'd0);
    end

    // Fill to DEPTH, then stall the completing byte of the next group
    for (int i = 0; i < DEPTH - 2; i++) send_word($urandom);
    check("t3_full_level", 32'(level), 32'(DEPTH));
    for (int k = 0; k < 3; k++) send_byte(8'($urandom));
    b3 = 8'($urandom);
    cycle(1'b1, b3, 1'b0, acc);
    check("t3_stall", 32'(acc), 32'd0);
    cycle(1'b1, b3, 1'b1, acc);
    check("t3_stall_pop", 32'(acc),   32'd0);
    check("t3_after_pop", 32'(level), 32'(DEPTH - 1));
    cycle(1'b1, b3, 1'b0, acc);
    check("t3_accept",     32'(acc),   32'd1);
    check("t3_level_full", 32'(level), 32'(DEPTH));

    // Drain with one multi-cycle request, then underflow
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, acc);
    check("t4_drained", 32'(level), 32'd0);
    cycle(1'b0, 8'h00, 1'b1, acc);
    check("t4_underflow", 32'(underflow), 32'd1);
    check("t4_idata",     idata,          32'd0);
    check("t4_level",     32'(level),     32'd0);
    send_word(32'hCAFEF00D);
    check("t4_uf_sticky", 32'(underflow), 32'd1);
    check("t4_level1",    32'(level),     32'd1);
    check("t4_head",      idata,          32'hCAFEF00D);

    // Simultaneous push and pop at level 3
    send_word(32'h01020304);
    send_word(32'hA5A55A5A);
    check("t5_level3", 32'(level), 32'd3);
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'hAD);
    cycle(1'b1, 8'h0B, 1'b1, acc);
    check("t5_accept", 32'(acc),   32'd1);
    check("t5_level",  32'(level), 32'd3);
    check("t5_head",   idata,      32'h01020304);

    // Asynchronous reset in the middle of a group
    send_byte(8'hDE);
    send_byte(8'hAD);
    #2 reset = 1'b1;
    #1;
    check("t6_s_ready",   32'(s_ready),   32'd1);
    check("t6_ready",     32'(ready),     32'd0);
    check("t6_idata",     idata,          32'd0);
    check("t6_level",     32'(level),     32'd0);
    check("t6_underflow", 32'(underflow), 32'd0);
    clear_model();
    @(posedge clk);
    #1 reset = 1'b0;
    send_word(32'h13579BDF);
    check("t6_clean_word", idata,      32'h13579BDF);
    check("t6_level1",     32'(level), 32'd1);

    // Random traffic: light draining first (fills and stalls), then heavy
    // draining (empties and underflows), with busy toggling throughout.
    busy = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      bit v;
      bit e;
      if ($urandom_range(15) == 0) busy = ~busy;
      v = ($urandom_range(3) != 0);
      e = (i < 800) ? ($urandom_range(7) == 0) : ($urandom_range(2) == 0);
      cycle(v, 8'($urandom), e, acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rnn_input_feeder
